// File: rtl/int_cond_pkg.sv
// Shared constants, register offsets and address decode for the interrupt source conditioner.
package int_cond_pkg;

    localparam int NUM_LINES = 4;
    localparam int FILT_W    = 8;

    localparam logic [31:0] ADDR_MODE    = 32'h0000_0000;
    localparam logic [31:0] ADDR_POL     = 32'h0000_0004;
    localparam logic [31:0] ADDR_PENDING = 32'h0000_0008;
    localparam logic [31:0] ADDR_MASK    = 32'h0000_000C;
    localparam logic [31:0] ADDR_FILTER  = 32'h0000_0010;
    localparam logic [31:0] ADDR_STATUS  = 32'h0000_0014;

    typedef enum logic [2:0] {
        REG_MODE,
        REG_POL,
        REG_PENDING,
        REG_MASK,
        REG_FILTER,
        REG_STATUS,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        reg_sel_e sel;
        case (addr)
            ADDR_MODE:    sel = REG_MODE;
            ADDR_POL:     sel = REG_POL;
            ADDR_PENDING: sel = REG_PENDING;
            ADDR_MASK:    sel = REG_MASK;
            ADDR_FILTER:  sel = REG_FILTER;
            ADDR_STATUS:  sel = REG_STATUS;
            default:      sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/int_line_filter.sv
// One interrupt line: 2-flop synchronizer, stable-count glitch filter and
// registered transition detect towards the active polarity.
module int_line_filter
    import int_cond_pkg::*;
(
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Raw,
    input  logic [FILT_W-1:0] i_Stable,
    input  logic              i_Pol,
    output logic              o_Filtered,
    output logic              o_Event
);

    logic              sync1_q, sync2_q;
    logic              filt_q, filt_d;
    logic              filt_prev_q;
    logic [FILT_W-1:0] cnt_q, cnt_d;

    // Counter restarts after each accepted change so a fresh run is measured.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == i_Stable) begin
            filt_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != {FILT_W{1'b1}}) begin
            cnt_d = cnt_q + FILT_W'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= i_Raw;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            cnt_q       <= cnt_d;
        end
    end

    assign o_Filtered = filt_q;
    assign o_Event    = (filt_q != filt_prev_q) && (filt_q == i_Pol);

endmodule

// File: rtl/int_source_conditioner.sv
// Conditions raw peripheral interrupt lines into pending requests for the
// interrupt controller; holds the register file and pending/clear logic.
module int_source_conditioner
    import int_cond_pkg::*;
(
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_WEnable,
    input  logic [31:0]          i_WAddr,
    input  logic [31:0]          i_WData,
    input  logic                 i_REnable,
    input  logic [31:0]          i_RAddr,
    output logic [31:0]          o_RData,
    output logic                 o_Err,
    input  logic [NUM_LINES-1:0] i_RawIrq,
    input  logic                 i_AckComplete,
    input  logic [1:0]           i_IrqNumber,
    output logic [NUM_LINES-1:0] o_IntSources
);

    logic [NUM_LINES-1:0] mode_q, mode_d, pol_q, pol_d;
    logic [NUM_LINES-1:0] pend_q, pend_d, mask_q, mask_d;
    logic [FILT_W-1:0]    filt_n_q, filt_n_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [NUM_LINES-1:0] filtered_w, event_w, w1c_w, ack_w, cfg_chg_w;
    reg_sel_e             wr_sel, rd_sel;
    logic                 unused_wdata;

    assign unused_wdata = ^i_WData[31:FILT_W];

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            int_line_filter u_filter (
                .i_Clk      (i_Clk),
                .i_Rst      (i_Rst),
                .i_Raw      (i_RawIrq[gi]),
                .i_Stable   (filt_n_q),
                .i_Pol      (pol_q[gi]),
                .o_Filtered (filtered_w[gi]),
                .o_Event    (event_w[gi])
            );
        end
    endgenerate

    always_comb begin
        wr_sel   = decode_addr(i_WAddr);
        rd_sel   = decode_addr(i_RAddr);
        mode_d   = mode_q;
        pol_d    = pol_q;
        mask_d   = mask_q;
        filt_n_d = filt_n_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        w1c_w    = '0;
        ack_w    = '0;
        pend_d   = pend_q;

        // A write takes the cycle; a simultaneous read is dropped.
        if (i_WEnable) begin
            err_d = 1'b0;
            case (wr_sel)
                REG_MODE:    mode_d   = i_WData[NUM_LINES-1:0];
                REG_POL:     pol_d    = i_WData[NUM_LINES-1:0];
                REG_PENDING: w1c_w    = i_WData[NUM_LINES-1:0];
                REG_MASK:    mask_d   = i_WData[NUM_LINES-1:0];
                REG_FILTER:  filt_n_d = i_WData[FILT_W-1:0];
                default:     err_d    = 1'b1;
            endcase
        end else if (i_REnable) begin
            err_d = 1'b0;
            case (rd_sel)
                REG_MODE:    rdata_d = {{(32-NUM_LINES){1'b0}}, mode_q};
                REG_POL:     rdata_d = {{(32-NUM_LINES){1'b0}}, pol_q};
                REG_PENDING: rdata_d = {{(32-NUM_LINES){1'b0}}, pend_q};
                REG_MASK:    rdata_d = {{(32-NUM_LINES){1'b0}}, mask_q};
                REG_FILTER:  rdata_d = {{(32-FILT_W){1'b0}}, filt_n_q};
                REG_STATUS:  rdata_d = {{(32-NUM_LINES){1'b0}}, filtered_w};
                default:     err_d   = 1'b1;
            endcase
        end

        if (i_AckComplete) begin
            ack_w[i_IrqNumber] = 1'b1;
        end
        cfg_chg_w = (mode_d ^ mode_q) | (pol_d ^ pol_q);

        // Reconfiguration wins, then level reload, then set-over-clear.
        for (int n = 0; n < NUM_LINES; n++) begin
            if (cfg_chg_w[n]) begin
                pend_d[n] = 1'b0;
            end else if (!mode_q[n]) begin
                pend_d[n] = (filtered_w[n] == pol_q[n]);
            end else if (event_w[n]) begin
                pend_d[n] = 1'b1;
            end else if (w1c_w[n] || ack_w[n]) begin
                pend_d[n] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            mode_q   <= '0;
            pol_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            filt_n_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            pol_q    <= pol_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            filt_n_q <= filt_n_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign o_RData      = rdata_q;
    assign o_Err        = err_q;
    assign o_IntSources = pend_q & mask_q;

endmodule

// File: doc/int_source_conditioner.md
INT_SOURCE_CONDITIONER -- requirements
Module: int_source_conditioner

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: i_Clk, i_Rst.
REQ-002 i_Clk  in  1  system clock; all state changes on its rising edge.
REQ-003 i_Rst  in  1  synchronous active-high reset.
REQ-004 i_WEnable  in  1  register write strobe, single cycle.
REQ-005 i_WAddr  in  32  write byte address.
REQ-006 i_WData  in  32  write data.
REQ-007 i_REnable  in  1  register read strobe, single cycle.
REQ-008 i_RAddr  in  32  read byte address.
REQ-009 o_RData  out  32  registered read data.
REQ-010 o_Err  out  1  registered access error flag.
REQ-011 i_RawIrq  in  4  asynchronous peripheral interrupt lines (UART, GPIO, ...).
REQ-012 i_AckComplete  in  1  one-cycle completion pulse from the interrupt controller.
REQ-013 i_IrqNumber  in  2  line index being serviced, valid with i_AckComplete.
REQ-014 o_IntSources  out  4  conditioned requests; drives the interrupt controller int_sources input.

Function
REQ-015 Register map, full 32-bit address match: 0x00 MODE (bit n: 1=edge, 0=level), 0x04 POLARITY (1=high/rising, 0=low/falling), 0x08 PENDING (R, write-1-to-clear), 0x0C MASK (1=enabled), 0x10 FILTER (bits[7:0], stable-cycle count N), 0x14 STATUS (R-only, filtered line states). Unused register bits read 0.
REQ-016 Per line: 2-flop synchronizer, then glitch filter, then event detect, then pending flop.
REQ-017 Filter: 8-bit counter per line; counter resets whenever synchronized value equals filtered value; filtered value takes synchronized value when they differ and counter equals N; otherwise counter increments, saturating at 255.
REQ-018 Latency: with N=0, o_IntSources[n] asserts on the 4th rising edge after i_RawIrq[n] transition is sampled; each unit of N adds exactly one edge.
REQ-019 Edge mode: pending[n] sets on the edge where filtered[n] transitions to the active polarity; holds until cleared.
REQ-020 Level mode: pending[n] is loaded every cycle with (filtered[n] == POLARITY[n]); W1C and ack have no lasting effect.
REQ-021 Clear sources (edge mode only): PENDING write with bit n=1; i_AckComplete with i_IrqNumber=n.
REQ-022 Set event and clear in the same cycle: set wins, pending stays 1.
REQ-023 o_IntSources = PENDING & MASK (combinational from registers); masked lines still latch pending.
REQ-024 Write to MODE or POLARITY clears PENDING bits of lines whose bit changed; filter state is unaffected.
REQ-025 Write and read strobes in the same cycle: the write executes, the read is ignored.
REQ-026 Valid access: o_Err<=0 next edge; read loads o_RData next edge.
REQ-027 Unmapped address, or write to 0x14: o_Err<=1; no register changes; o_RData holds.
REQ-028 No strobe: o_Err and o_RData hold.

Reset
REQ-029 With i_Rst high at an edge: MODE, POLARITY, PENDING, MASK, FILTER, sync flops, filtered values, counters, o_RData, o_Err all 0; o_IntSources=0.
REQ-030 Reset overrides all strobes and events in that cycle; an edge in flight when reset occurs is discarded.

Structure
REQ-031 Package int_cond_pkg SHALL hold NUM_LINES=4, FILT_W=8, and register offset constants 0x00-0x14.
REQ-032 Sub-module int_line_filter (synchronizer, counter, filtered value, event output) SHALL be instantiated NUM_LINES times; register file and pending logic stay in the top module.

Verification
REQ-033 MODE=0xF, POLARITY=0xF, MASK=0xF, N=0; raw[1] rises -> o_IntSources=0x2 exactly on the 4th edge; remains set after raw[1] falls.
REQ-034 N=3; raw[0] 2-cycle high glitch -> no pending; 6-cycle high pulse -> pending[0] on the 7th edge.
REQ-035 pending[2] set; i_AckComplete with i_IrqNumber=2 -> PENDING=0x0 next edge; repeat with a new rising event in the same cycle -> PENDING stays 0x4.
REQ-036 Level mode, POLARITY[3]=0; raw[3] low -> o_IntSources[3]=1; W1C 0x8 -> still 1; raw high -> 0 after latency.
REQ-037 Read 0x20 -> o_Err=1, o_RData unchanged; write 0x14 -> o_Err=1; read 0x0C -> o_Err=0, o_RData=MASK.
REQ-038 Assert i_Rst mid-filter count with pending=0xF -> all outputs 0 next edge; after release, first event again needs full latency.
